pll_reset_seq: RTL and testbench

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_reset_seq_pkg.sv | 41 ++++
 rtl/sync_1bit.sv | 24 ++
 rtl/pll_reset_seq.sv | 162 ++++++++++++++++
 tb/tb_pll_reset_seq.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_seq_pkg.sv
// Shared clocking definitions: FSM state encodings for the PLL
// reset sequencer plus the counter sizing helper.
//
// State encodings are plain localparams so a status-register decode
// can import this package and match the `state` port bit for bit.
package pll_reset_seq_pkg;

    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_FILTER    = 3'd2;
    localparam logic [2:0] ST_RELEASE   = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;

    typedef enum logic [2:0] {
        S_PLL_RST   = ST_PLL_RST,
        S_WAIT_LOCK = ST_WAIT_LOCK,
        S_FILTER    = ST_FILTER,
        S_RELEASE   = ST_RELEASE,
        S_RUN       = ST_RUN
    } seq_state_e;

    // Width of the one counter shared by every timed state.
    // Never narrower than one bit.
    function automatic int cnt_width(
        input int a,
        input int b,
        input int c,
        input int d
    );
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        w = $clog2(m);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/sync_1bit.sv
// Single-bit multi-flop synchroniser with async active-low clear.
// Ports: clk, rst_n, d (async input), q (synchronised output).
module sync_1bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses PLL RESETB, filters LOCK, then releases
// per-domain resets in a staggered order; restarts on lock loss,
// lock timeout or relock request.
//
// Ports:
//   clk           free-running reference clock
//   rst_n         async active-low reset
//   pll_lock      PLL LOCK (async to clk)
//   relock_req    one-cycle request to restart the PLL
//   pll_resetb    PLL RESETB, active-low
//   domain_rst_n  per-domain active-low resets
//   ready         high only in RUN
//   timeout_count saturating count of lock timeouts
//   state         current FSM state encoding
module pll_reset_seq
    import pll_reset_seq_pkg::*;
#(
    parameter int N_DOMAINS      = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_FILTER    = 256,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STAGGER        = 8,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pll_lock,
    input  logic                 relock_req,
    output logic                 pll_resetb,
    output logic [N_DOMAINS-1:0] domain_rst_n,
    output logic                 ready,
    output logic [7:0]           timeout_count,
    output logic [2:0]           state
);

    localparam int CW = cnt_width(
        PLL_RST_CYCLES,
        LOCK_FILTER,
        LOCK_TIMEOUT,
        N_DOMAINS * STAGGER + 1
    );

    localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    // One past the release of the last domain: the RUN entry edge.
    localparam logic [CW-1:0] REL_DONE  =
        CW'((N_DOMAINS - 1) * STAGGER + 1);

    seq_state_e           st;
    logic [CW-1:0]        cnt;
    logic                 lock_s;
    logic                 fault;
    logic [N_DOMAINS-1:0] rel_hit;

    sync_1bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // Domains whose release slot matches the current counter value.
    always_comb begin
        rel_hit = '0;
        for (int i = 0; i < N_DOMAINS; i++) begin
            rel_hit[i] = (cnt == CW'(i * STAGGER));
        end
    end

    // Relock is honoured everywhere except PLL_RST; lock loss only
    // matters once domains are being (or have been) released.
    always_comb begin
        fault = 1'b0;
        if (st != S_PLL_RST && relock_req) begin
            fault = 1'b1;
        end
        if ((st == S_RELEASE || st == S_RUN) && !lock_s) begin
            fault = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= S_PLL_RST;
            cnt           <= '0;
            pll_resetb    <= 1'b0;
            domain_rst_n  <= '0;
            ready         <= 1'b0;
            timeout_count <= '0;
        end else if (fault) begin
            // Fault restarts never touch timeout_count.
            st           <= S_PLL_RST;
            cnt          <= '0;
            pll_resetb   <= 1'b0;
            domain_rst_n <= '0;
            ready        <= 1'b0;
        end else begin
            unique case (st)
                S_PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        st         <= S_WAIT_LOCK;
                        cnt        <= '0;
                        pll_resetb <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        st  <= S_FILTER;
                        cnt <= '0;
                    end else if (cnt == TO_LAST) begin
                        st         <= S_PLL_RST;
                        cnt        <= '0;
                        pll_resetb <= 1'b0;
                        if (timeout_count != 8'hFF) begin
                            timeout_count <= timeout_count + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_FILTER: begin
                    if (!lock_s) begin
                        st  <= S_WAIT_LOCK;
                        cnt <= '0;
                    end else if (cnt == FILT_LAST) begin
                        st  <= S_RELEASE;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RELEASE: begin
                    if (cnt == REL_DONE) begin
                        st    <= S_RUN;
                        ready <= 1'b1;
                    end else begin
                        domain_rst_n <= domain_rst_n | rel_hit;
                        cnt          <= cnt + CW'(1);
                    end
                end
                S_RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    st           <= S_PLL_RST;
                    cnt          <= '0;
                    pll_resetb   <= 1'b0;
                    domain_rst_n <= '0;
                    ready        <= 1'b0;
                end
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq.
// Expected per-cycle output words are queued, then popped per cycle.
module tb_pll_reset_seq;
    import pll_reset_seq_pkg::*;

    localparam int N   = 3;
    localparam int PRC = 4;
    localparam int LF  = 8;
    localparam int LT  = 32;
    localparam int S   = 2;
    localparam int SS  = 2;

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b1;
    logic         pll_lock   = 1'b0;
    logic         relock_req = 1'b0;
    logic         pll_resetb;
    logic [N-1:0] domain_rst_n;
    logic         ready;
    logic [7:0]   timeout_count;
    logic [2:0]   state;

    logic [15:0] obs;
    logic [15:0] want;
    logic [15:0] exp_q[$];
    int total  = 0;
    int passed = 0;

    assign obs = {pll_resetb, domain_rst_n, ready, timeout_count, state};

    always #5 clk = ~clk;

    pll_reset_seq #(
        .N_DOMAINS      (N),
        .PLL_RST_CYCLES (PRC),
        .LOCK_FILTER    (LF),
        .LOCK_TIMEOUT   (LT),
        .STAGGER        (S),
        .SYNC_STAGES    (SS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_lock      (pll_lock),
        .relock_req    (relock_req),
        .pll_resetb    (pll_resetb),
        .domain_rst_n  (domain_rst_n),
        .ready         (ready),
        .timeout_count (timeout_count),
        .state         (state)
    );

    function automatic logic [15:0] pk(
        input logic [2:0] st,
        input logic       rb,
        input logic [2:0] dom,
        input logic       rdy,
        input logic [7:0] tc
    );
        return {rb, dom, rdy, tc, st};
    endfunction

    // Expected output after edge k of a bring-up sequence:
    // PLL_RST entered at edge e0, pll_lock raised after edge l.
    function automatic logic [15:0] up_exp(
        input int         k,
        input int         e0,
        input int         l,
        input logic [7:0] tc
    );
        int f;
        int r;
        int c;
        logic [2:0] dom;
        f = l + SS + 1;
        r = f + LF;
        if (k < e0 + PRC) return pk(ST_PLL_RST, 1'b0, 3'b000, 1'b0, tc);
        if (k < f) return pk(ST_WAIT_LOCK, 1'b1, 3'b000, 1'b0, tc);
        if (k < r) return pk(ST_FILTER, 1'b1, 3'b000, 1'b0, tc);
        if (k == r) return pk(ST_RELEASE, 1'b1, 3'b000, 1'b0, tc);
        c = k - r - 1;
        dom = '0;
        for (int i = 0; i < N; i++) begin
            if (c >= i * S) dom[i] = 1'b1;
        end
        if (c > (N - 1) * S) return pk(ST_RUN, 1'b1, dom, 1'b1, tc);
        return pk(ST_RELEASE, 1'b1, dom, 1'b0, tc);
    endfunction

    task automatic do_reset(input logic lock);
        @(negedge clk);
        rst_n      = 1'b0;
        pll_lock   = lock;
        relock_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        rst_n = 1'b0;
        exp_q.push_back(pk(ST_PLL_RST, 1'b0, 3'b000, 1'b0, 8'd0));
        exp_q.push_back(pk(ST_PLL_RST, 1'b0, 3'b000, 1'b0, 8'd0));
        #1;
        want = exp_q.pop_front();
        total++;
        if (obs !== want)
            $display("FAIL reset_async: got %h want %h", obs, want);
        else
            passed++;
        repeat (2) @(negedge clk);
        want = exp_q.pop_front();
        total++;
        if (obs !== want)
            $display("FAIL reset_held: got %h want %h", obs, want);
        else
            passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_power_up();
        do_reset(1'b0);
        for (int k = 1; k <= 30; k++) exp_q.push_back(up_exp(k, 0, 9, 8'd0));
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            want = exp_q.pop_front();
            total++;
            if (obs !== want)
                $display("FAIL power_up k=%0d: got %h want %h", k, obs, want);
            else
                passed++;
            if (k == 9) pll_lock = 1'b1;
        end
    endtask

    task automatic test_timeout();
        int n;
        int p;
        logic low;
        do_reset(1'b0);
        for (int k = 1; k <= 112; k++) begin
            n = (k >= 36) ? (k - 36) / 36 + 1 : 0;
            p = (k < 36) ? k : (k - 36) % 36;
            low = (k < PRC) || (k >= 36 && p < PRC);
            exp_q.push_back(pk(low ? ST_PLL_RST : ST_WAIT_LOCK, !low,
                               3'b000, 1'b0, 8'(n)));
        end
        for (int k = 1; k <= 112; k++) begin
            @(negedge clk);
            want = exp_q.pop_front();
            total++;
            if (obs !== want)
                $display("FAIL timeout k=%0d: got %h want %h", k, obs, want);
            else
                passed++;
        end
    endtask

    task automatic test_saturation();
        do_reset(1'b0);
        exp_q.push_back({8'd0, 8'hFF});
        repeat (256 * 36 + 40) @(negedge clk);
        want = exp_q.pop_front();
        total++;
        if ({8'd0, timeout_count} !== want)
            $display("FAIL saturation: got %h want %h",
                     timeout_count, want[7:0]);
        else
            passed++;
    endtask

    task automatic test_glitch();
        do_reset(1'b0);
        for (int k = 1; k <= 36; k++) begin
            if (k < 17) exp_q.push_back(up_exp(k, 0, 9, 8'd0));
            else        exp_q.push_back(up_exp(k, 0, 17, 8'd0));
        end
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            want = exp_q.pop_front();
            total++;
            if (obs !== want)
                $display("FAIL glitch k=%0d: got %h want %h", k, obs, want);
            else
                passed++;
            if (k == 9)  pll_lock = 1'b1;
            if (k == 14) pll_lock = 1'b0;
            if (k == 17) pll_lock = 1'b1;
        end
    endtask

    task automatic test_lock_loss();
        do_reset(1'b0);
        for (int k = 1; k <= 60; k++) begin
            if (k < 33) exp_q.push_back(up_exp(k, 0, 9, 8'd0));
            else        exp_q.push_back(up_exp(k, 33, 40, 8'd0));
        end
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            want = exp_q.pop_front();
            total++;
            if (obs !== want)
                $display("FAIL lock_loss k=%0d: got %h want %h", k, obs, want);
            else
                passed++;
            if (k == 9)  pll_lock = 1'b1;
            if (k == 30) pll_lock = 1'b0;
            if (k == 40) pll_lock = 1'b1;
        end
    endtask

    task automatic test_relock();
        do_reset(1'b0);
        for (int k = 1; k <= 52; k++) begin
            if (k < 30) exp_q.push_back(up_exp(k, 0, 9, 8'd0));
            else        exp_q.push_back(up_exp(k, 30, 32, 8'd0));
        end
        for (int k = 1; k <= 52; k++) begin
            @(negedge clk);
            want = exp_q.pop_front();
            total++;
            if (obs !== want)
                $display("FAIL relock k=%0d: got %h want %h", k, obs, want);
            else
                passed++;
            if (k == 9)  pll_lock = 1'b1;
            if (k == 29) relock_req = 1'b1;
            if (k == 30) relock_req = 1'b0;
        end
    endtask

    task automatic test_relock_and_loss();
        do_reset(1'b0);
        for (int k = 1; k <= 78; k++) begin
            if (k < 36)      exp_q.push_back(up_exp(k, 0, 1000, 8'd0));
            else if (k < 68) exp_q.push_back(up_exp(k, 36, 45, 8'd1));
            else             exp_q.push_back(up_exp(k, 68, 1000, 8'd1));
        end
        for (int k = 1; k <= 78; k++) begin
            @(negedge clk);
            want = exp_q.pop_front();
            total++;
            if (obs !== want)
                $display("FAIL relock_loss k=%0d: got %h want %h", k, obs, want);
            else
                passed++;
            if (k == 45) pll_lock = 1'b1;
            if (k == 65) pll_lock = 1'b0;
            if (k == 67) relock_req = 1'b1;
            if (k == 68) relock_req = 1'b0;
            if (k == 69) relock_req = 1'b1;
            if (k == 70) relock_req = 1'b0;
        end
    endtask

    task automatic test_async_mid_release();
        do_reset(1'b0);
        for (int k = 1; k <= 22; k++) exp_q.push_back(up_exp(k, 0, 9, 8'd0));
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            want = exp_q.pop_front();
            total++;
            if (obs !== want)
                $display("FAIL mid_release k=%0d: got %h want %h", k, obs, want);
            else
                passed++;
            if (k == 9) pll_lock = 1'b1;
        end
        exp_q.push_back(pk(ST_PLL_RST, 1'b0, 3'b000, 1'b0, 8'd0));
        #2;
        rst_n = 1'b0;
        #1;
        want = exp_q.pop_front();
        total++;
        if (obs !== want)
            $display("FAIL async_clear: got %h want %h", obs, want);
        else
            passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 14; k++) exp_q.push_back(up_exp(k, 0, 2, 8'd0));
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            want = exp_q.pop_front();
            total++;
            if (obs !== want)
                $display("FAIL restart k=%0d: got %h want %h", k, obs, want);
            else
                passed++;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_power_up();
        test_timeout();
        test_glitch();
        test_lock_loss();
        test_relock();
        test_relock_and_loss();
        test_async_mid_release();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
